// File: rtl/future_round_ctrl_pkg.sv
// future_pkg: shared types and constants for the FUTURE cipher round controller.
package future_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
  localparam int BLOCK_W = 64;
  localparam int FUTURE_NUM_ROUNDS = 10;
endpackage

// File: rtl/xor64bit.sv
// xor64bit: bitwise 64-bit XOR used for AddRoundKey.
module xor64bit
  import future_pkg::*;
(
  input  logic [0:BLOCK_W-1] a,
  input  logic [0:BLOCK_W-1] b,
  output logic [0:BLOCK_W-1] y
);
  assign y = a ^ b;
endmodule

// File: rtl/future_round_ctrl.sv
// future_round_ctrl: iterative FUTURE encryption sequencer (whitening + NUM_ROUNDS rounds).
// Optional FUTURE_CTRL_ABORT_EN adds a synchronous abort input.
module future_round_ctrl
  import future_pkg::*;
#(
  parameter int NUM_ROUNDS = FUTURE_NUM_ROUNDS,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef FUTURE_CTRL_ABORT_EN
  input  logic               abort,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:BLOCK_W-1] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:BLOCK_W-1] out_data,
  output logic               busy,
  output logic [IDX_W-1:0]   rk_idx,
  input  logic [0:BLOCK_W-1] rk,
  output logic [0:BLOCK_W-1] rf_in,
  input  logic [0:BLOCK_W-1] rf_out,
  output logic               last_round
);
  fsm_t fsm, fsm_n;
  logic [0:BLOCK_W-1] data, data_n, xor_a, xor_y;
  logic [IDX_W-1:0] cnt, cnt_n;
  logic kill;
`ifdef FUTURE_CTRL_ABORT_EN
  assign kill = abort && fsm != IDLE;
`else
  assign kill = 1'b0;
`endif
  xor64bit u_ark (.a(xor_a), .b(rk), .y(xor_y));
  assign xor_a = fsm == ROUND ? rf_out : in_data;
  assign in_ready = fsm == IDLE;
  assign out_valid = fsm == DONE;
  assign busy = fsm != IDLE;
  assign rk_idx = fsm == ROUND ? cnt : '0;
  assign last_round = fsm == ROUND && cnt == IDX_W'(NUM_ROUNDS);
  assign rf_in = data;
  assign out_data = data;
  always_comb begin
    fsm_n = fsm;
    data_n = data;
    cnt_n = cnt;
    unique case (fsm)
      IDLE: if (in_valid) begin
        data_n = xor_y;
        cnt_n = IDX_W'(1);
        fsm_n = ROUND;
      end
      ROUND: begin
        data_n = xor_y;
        fsm_n = cnt == IDX_W'(NUM_ROUNDS) ? DONE : ROUND;
        cnt_n = cnt == IDX_W'(NUM_ROUNDS) ? cnt : cnt + IDX_W'(1);
      end
      DONE: fsm_n = out_ready ? IDLE : DONE;
      default: fsm_n = IDLE;
    endcase
    if (kill) begin
      fsm_n = IDLE;
      data_n = '0;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= IDLE;
      data <= '0;
      cnt <= '0;
    end else begin
      fsm <= fsm_n;
      data <= data_n;
      cnt <= cnt_n;
    end
  end
endmodule
